// File: rtl/c_result_drain.sv
`default_nettype none
// ============================================================================
// Module   : c_result_drain
// Brief    : Walks the flattened C result BRAM and streams every entry out as
//            one Avalon-ST packet, using credit-based read issue into a small
//            output FIFO. Define DRAIN_COLMAJOR_EN for column-major order.
// Revision : 1.0 - initial release
// ============================================================================
module c_result_drain #(
    parameter int DATA_WIDTH   = 16,
    parameter int M            = 3,
    parameter int K            = 3,
    parameter int N            = 3,
    parameter int FIFO_DEPTH   = 4,
    parameter int READ_LATENCY = 1,
    localparam int ACC_WIDTH    = 2*DATA_WIDTH + ((K > 1) ? $clog2(K) : 1),
    // A single-entry matrix still needs a one-bit address port
    localparam int ADDR_WIDTH_C = (M*N > 1) ? $clog2(M*N) : 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    mult_done,
    input  logic                    drain_start,
    output logic                    c_rd_en,
    output logic [ADDR_WIDTH_C-1:0] c_rd_addr,
    input  logic [ACC_WIDTH-1:0]    c_rd_data,
    output logic [ACC_WIDTH-1:0]    st_data,
    output logic                    st_valid,
    input  logic                    st_ready,
    output logic                    st_sop,
    output logic                    st_eop,
    output logic                    busy,
    output logic                    done
);

    localparam int C_TOTAL = M*N;
    localparam int C_PTR_W = $clog2(FIFO_DEPTH);
    localparam int C_OCC_W = C_PTR_W + 2;
    localparam logic [ADDR_WIDTH_C-1:0] C_LAST = ADDR_WIDTH_C'(C_TOTAL - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [ADDR_WIDTH_C-1:0] r_issue_cnt;
    logic [READ_LATENCY-1:0] r_dl_v;
    logic [READ_LATENCY-1:0] r_dl_sop;
    logic [READ_LATENCY-1:0] r_dl_eop;
    logic [C_PTR_W:0]        r_count;
    logic [C_PTR_W-1:0]      r_wr_ptr;
    logic [C_PTR_W-1:0]      r_rd_ptr;
    logic [ACC_WIDTH+1:0]    r_mem [FIFO_DEPTH];

    logic                    w_start;
    logic                    w_issue;
    logic                    w_last_issue;
    logic                    w_credit;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_drained;
    logic [C_OCC_W-1:0]      w_occupancy;
    logic [ADDR_WIDTH_C-1:0] w_addr;
    logic [ACC_WIDTH+1:0]    w_head;

    assign w_start      = (r_state == S_IDLE) && drain_start && mult_done;
    assign w_last_issue = (r_issue_cnt == C_LAST);
    // Reads in flight already own a FIFO slot, so the FIFO can never overflow
    assign w_occupancy  = C_OCC_W'(r_count) + C_OCC_W'($countones(r_dl_v));
    assign w_credit     = (w_occupancy < C_OCC_W'(FIFO_DEPTH));
    assign w_push       = r_dl_v[READ_LATENCY-1];
    assign w_pop        = st_valid && st_ready;
    assign w_drained    = (r_dl_v == '0) &&
                          ((r_count == '0) || ((r_count == (C_PTR_W+1)'(1)) && w_pop));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                busy    = 1'b1;
                w_issue = w_credit;
                if (w_credit && w_last_issue) begin
                    w_state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                busy = 1'b1;
                if (w_drained) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign c_rd_en = w_issue;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_issue_cnt <= '0;
        end else if (w_start) begin
            r_issue_cnt <= '0;
        end else if (w_issue && !w_last_issue) begin
            r_issue_cnt <= r_issue_cnt + ADDR_WIDTH_C'(1);
        end
    end

`ifdef DRAIN_COLMAJOR_EN
    localparam int C_ROW_W = (M > 1) ? $clog2(M) : 1;
    localparam int C_COL_W = (N > 1) ? $clog2(N) : 1;

    logic [C_ROW_W-1:0] r_row;
    logic [C_COL_W-1:0] r_col;

    // Row is the inner index: walk down a column before moving right
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_start) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_issue && !w_last_issue) begin
            if (r_row == C_ROW_W'(M - 1)) begin
                r_row <= '0;
                r_col <= r_col + C_COL_W'(1);
            end else begin
                r_row <= r_row + C_ROW_W'(1);
            end
        end
    end

    assign w_addr = ADDR_WIDTH_C'(int'(r_row) * N + int'(r_col));
`else
    assign w_addr = r_issue_cnt;
`endif

    assign c_rd_addr = w_addr;

    // Tags ride alongside the BRAM latency so they meet their data at the FIFO
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dl_v   <= '0;
            r_dl_sop <= '0;
            r_dl_eop <= '0;
        end else begin
            r_dl_v[0]   <= w_issue;
            r_dl_sop[0] <= w_issue && (r_issue_cnt == '0);
            r_dl_eop[0] <= w_issue && w_last_issue;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_dl_v[i]   <= r_dl_v[i-1];
                r_dl_sop[i] <= r_dl_sop[i-1];
                r_dl_eop[i] <= r_dl_eop[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {r_dl_sop[READ_LATENCY-1], r_dl_eop[READ_LATENCY-1], c_rd_data};
                r_wr_ptr        <= r_wr_ptr + C_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (C_PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (C_PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head   = r_mem[r_rd_ptr];
    assign st_valid = (r_count != '0);
    assign st_data  = w_head[ACC_WIDTH-1:0];
    assign st_eop   = w_head[ACC_WIDTH];
    assign st_sop   = w_head[ACC_WIDTH+1];

endmodule
`default_nettype wire

// File: tb/tb_c_result_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_c_result_drain
// Brief    : Directed/randomised bench for c_result_drain with a BRAM model
//            and a packet-level reference of the expected drain order.
// Revision : 1.0 - initial release
// ============================================================================
module tb_c_result_drain;

    localparam int DW    = 16;
    localparam int M     = 3;
    localparam int K     = 3;
    localparam int N     = 3;
    localparam int DEPTH = 4;
    localparam int RL    = 3;
    localparam int ACC   = 2*DW + ((K > 1) ? $clog2(K) : 1);
    localparam int AW    = (M*N > 1) ? $clog2(M*N) : 1;
    localparam int TOTAL = M*N;

    logic           clk = 1'b0;
    logic           reset_n = 1'b1;
    logic           mult_done = 1'b0;
    logic           drain_start = 1'b0;
    logic           st_ready = 1'b0;
    logic           c_rd_en;
    logic [AW-1:0]  c_rd_addr;
    logic [ACC-1:0] c_rd_data;
    logic [ACC-1:0] st_data;
    logic           st_valid;
    logic           st_sop;
    logic           st_eop;
    logic           busy;
    logic           done;

    always #5 clk = ~clk;

    c_result_drain #(
        .DATA_WIDTH  (DW),
        .M           (M),
        .K           (K),
        .N           (N),
        .FIFO_DEPTH  (DEPTH),
        .READ_LATENCY(RL)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .mult_done  (mult_done),
        .drain_start(drain_start),
        .c_rd_en    (c_rd_en),
        .c_rd_addr  (c_rd_addr),
        .c_rd_data  (c_rd_data),
        .st_data    (st_data),
        .st_valid   (st_valid),
        .st_ready   (st_ready),
        .st_sop     (st_sop),
        .st_eop     (st_eop),
        .busy       (busy),
        .done       (done)
    );

    // C BRAM: fixed read latency, garbage on the bus when not reading
    logic [ACC-1:0] cmem    [TOTAL];
    logic [ACC-1:0] rd_pipe [RL];
    always @(posedge clk) begin
        rd_pipe[0] <= c_rd_en ? cmem[c_rd_addr] : ACC'({$urandom(), $urandom()});
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign c_rd_data = rd_pipe[RL-1];

    typedef struct {
        logic [ACC-1:0] d;
        logic           sop;
        logic           eop;
        int             cyc;
    } beat_t;

    int             n_checks = 0;
    int             n_errors = 0;
    int             cyc = 0;
    int             outstanding = 0;
    int             done_cyc = -1;
    int             done_cnt = 0;
    int             iss_q[$];
    beat_t          beat_q[$];
    logic           prev_stall = 1'b0;
    logic [ACC+1:0] prev_beat = '0;
    int             exp_addr[TOTAL];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Observe the current cycle mid-period, then advance to just after the next edge
    task automatic tick();
        #4;
        if (reset_n) begin
            if (prev_stall) begin
                check("hold_valid", st_valid, 1);
                check("hold_beat", {st_sop, st_eop, st_data}, prev_beat);
            end
            if (c_rd_en) begin
                iss_q.push_back(int'(c_rd_addr));
                outstanding++;
            end
            check("credit_bound", (outstanding <= DEPTH) && (outstanding >= 0), 1);
            if (st_valid && st_ready) begin
                beat_q.push_back('{st_data, st_sop, st_eop, cyc});
                outstanding--;
            end
            if (done) begin
                done_cyc = cyc;
                done_cnt++;
            end
            prev_stall = st_valid && !st_ready;
            prev_beat  = {st_sop, st_eop, st_data};
        end else begin
            prev_stall  = 1'b0;
            outstanding = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic start_drain();
        mult_done   = 1'b1;
        drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
    endtask

    task automatic run_to_done(input int mode, input int bound);
        int k;
        int d0;
        k  = 0;
        d0 = done_cnt;
        while ((done_cnt == d0) && (k < bound)) begin
            case (mode)
                0:       st_ready = 1'b1;
                1:       st_ready = ((k >= 6) && (k < 16)) ? 1'b0 : ((k % 2) == 0);
                default: st_ready = 1'($urandom_range(0, 1));
            endcase
            tick();
            k++;
        end
        check("done_seen", done_cnt != d0, 1);
        st_ready = 1'b1;
    endtask

    task automatic check_packet(input string tag, input int bb, input int ib);
        check({tag, "_beats"}, beat_q.size() - bb, TOTAL);
        check({tag, "_reads"}, iss_q.size() - ib, TOTAL);
        if ((beat_q.size() - bb == TOTAL) && (iss_q.size() - ib == TOTAL)) begin
            for (int k = 0; k < TOTAL; k++) begin
                check($sformatf("%s_addr%0d", tag, k), iss_q[ib+k], exp_addr[k]);
                check($sformatf("%s_data%0d", tag, k), beat_q[bb+k].d, cmem[exp_addr[k]]);
                check($sformatf("%s_sop%0d", tag, k), beat_q[bb+k].sop, (k == 0));
                check($sformatf("%s_eop%0d", tag, k), beat_q[bb+k].eop, (k == TOTAL-1));
            end
            check({tag, "_done_timing"}, done_cyc, beat_q[bb+TOTAL-1].cyc + 1);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_rd_en"}, c_rd_en, 0);
        check({tag, "_rd_addr"}, c_rd_addr, 0);
        check({tag, "_valid"}, st_valid, 0);
        check({tag, "_sop"}, st_sop, 0);
        check({tag, "_eop"}, st_eop, 0);
        check({tag, "_data"}, st_data, 0);
    endtask

    task automatic randomize_c();
        for (int i = 0; i < TOTAL; i++) cmem[i] = ACC'({$urandom(), $urandom()});
    endtask

    initial begin
        int bb;
        int ib;
        int d0;
        int kk;

`ifdef DRAIN_COLMAJOR_EN
        kk = 0;
        for (int c = 0; c < N; c++) begin
            for (int r = 0; r < M; r++) begin
                exp_addr[kk] = r*N + c;
                kk++;
            end
        end
`else
        for (int i = 0; i < TOTAL; i++) exp_addr[i] = i;
`endif
        for (int i = 0; i < TOTAL; i++) cmem[i] = ACC'(i + 100);

        #1 reset_n = 1'b0;
        #5;
        repeat (3) tick();
        check_idle_outputs("reset");
        reset_n = 1'b1;
        tick();
        check_idle_outputs("post_reset");

        // Directed packet with fixed contents and exact first-beat latency
        bb = beat_q.size();
        ib = iss_q.size();
        st_ready = 1'b1;
        start_drain();
        check("t1_first_rd_en", c_rd_en, 1);
        check("t1_first_addr", c_rd_addr, exp_addr[0]);
        check("t1_busy", busy, 1);
        repeat (RL) tick();
        check("t1_valid_early", st_valid, 0);
        tick();
        check("t1_first_valid", st_valid, 1);
        run_to_done(0, 100);
        check_packet("t1", bb, ib);
        tick();
        check("t1_idle_busy", busy, 0);

        // Backpressure: toggling ready with a long hold, then random ready
        randomize_c();
        bb = beat_q.size();
        ib = iss_q.size();
        start_drain();
        run_to_done(1, 200);
        check_packet("t2a", bb, ib);
        randomize_c();
        bb = beat_q.size();
        ib = iss_q.size();
        start_drain();
        run_to_done(2, 300);
        check_packet("t2b", bb, ib);

        // Start without mult_done is ignored; restart while busy is ignored
        ib = iss_q.size();
        mult_done   = 1'b0;
        drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
        repeat (5) tick();
        check("t3_no_busy", busy, 0);
        check("t3_no_reads", iss_q.size() - ib, 0);
        randomize_c();
        bb = beat_q.size();
        ib = iss_q.size();
        d0 = done_cnt;
        start_drain();
        tick();
        drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
        mult_done   = 1'b0;
        run_to_done(2, 300);
        check_packet("t3", bb, ib);
        repeat (6) tick();
        check("t3_single_done", done_cnt - d0, 1);
        check("t3_no_extra_reads", iss_q.size() - ib, TOTAL);
        check("t3_idle", busy, 0);

        // Sink stalled: issue must stop once every FIFO slot is claimed
        randomize_c();
        bb = beat_q.size();
        ib = iss_q.size();
        st_ready = 1'b0;
        start_drain();
        repeat (20) tick();
        check("t4_reads_stalled", iss_q.size() - ib, DEPTH);
        check("t4_valid", st_valid, 1);
        check("t4_no_beats", beat_q.size() - bb, 0);
        check("t4_busy", busy, 1);
        run_to_done(0, 200);
        check_packet("t4", bb, ib);

        // Asynchronous reset mid-packet, then a clean full packet
        randomize_c();
        bb = beat_q.size();
        st_ready = 1'b1;
        start_drain();
        kk = 0;
        while ((beat_q.size() - bb < 5) && (kk < 60)) begin
            tick();
            kk++;
        end
        check("t5_reached_beat4", beat_q.size() - bb >= 5, 1);
        d0 = done_cnt;
        #2 reset_n = 1'b0;
        #1;
        check_idle_outputs("t5_async");
        @(posedge clk);
        #1;
        cyc++;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        check("t5_no_done", done_cnt - d0, 0);
        check_idle_outputs("t5_after");
        bb = beat_q.size();
        ib = iss_q.size();
        start_drain();
        run_to_done(0, 100);
        check_packet("t5", bb, ib);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
